serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_if.sv | 29 ++
 rtl/full_adder.sv | 16 +
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Purpose: shared FSM encoding, default operand width and counter sizing for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

   // Operand width used when the parent does not override N.
   localparam int DEFAULT_N = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The bit counter only has to reach N-1, so $clog2(N) bits suffice.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Purpose: operand/result bundle between a requester and the bit-serial adder.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while the adder is not idle.
// Signals: start, a, b, cin  (requester -> adder)
//          sum, cout, busy, done (adder -> requester)
interface serial_adder_if #(
   parameter int N = serial_adder_pkg::DEFAULT_N
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic [N-1:0] sum;
   logic         cout;
   logic         busy;
   logic         done;

   // Requester side.
   modport master (
      output start, a, b, cin,
      input  sum, cout, busy, done
   );

   // Adder side.
   modport slave (
      input  start, a, b, cin,
      output sum, cout, busy, done
   );
endinterface

// File: rtl/full_adder.sv
// Purpose: one-bit full-adder cell, used as the serial bit slice.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y, cin (addend bits and carry in); s (sum bit); cout (carry out).
module full_adder (
   output logic cout,
   output logic s,
   input  logic x,
   input  logic y,
   input  logic cin
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Purpose: adds two N-bit operands plus carry-in one bit per clock through a single full-adder cell.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+N; next start accepted at k+N+2.
// Backpressure: start is honoured only in IDLE; requests during ADD/DONE are dropped, never queued.
// Ports: clk, rst_n (async active-low); bus.slave carries start/a/b/cin in and sum/cout/busy/done out.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int CW = cnt_width(N);

   state_t        state;
   logic [N-1:0]  op_a;
   logic [N-1:0]  op_b;
   logic [N-1:0]  sum_q;
   logic          carry;
   logic          cout_q;
   logic          busy_q;
   logic          done_q;
   logic [CW-1:0] cnt;

   logic          fa_s;
   logic          fa_c;
   logic          last_bit;

   // The counter tracks which bit is being added; bit N-1 is the final one.
   assign last_bit = (cnt == CW'(N - 1));

   // Operand LSBs and the carry flop feed the single bit slice.
   full_adder u_fa (
      .cout (fa_c),
      .s    (fa_s),
      .x    (op_a[0]),
      .y    (op_b[0]),
      .cin  (carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_a   <= '0;
         op_b   <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt    <= '0;
      end else begin
         // done is a single-cycle strobe; only the final ADD cycle raises it.
         done_q <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_a   <= bus.a;
                  op_b   <= bus.b;
                  carry  <= bus.cin;
                  cnt    <= '0;
                  sum_q  <= '0;
                  cout_q <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= ADD;
               end
            end

            ADD: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               // Sum bits enter at the MSB, so after N shifts bit 0 lands at the LSB.
               sum_q <= {fa_s, sum_q[N-1:1]};
               carry <= fa_c;
               if (last_bit) begin
                  cout_q <= fa_c;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  // Holding at N-1 on the last bit keeps the counter from wrapping
                  // when N is a power of two.
                  cnt <= cnt + CW'(1);
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Purpose: self-checking bench for serial_adder with a scoreboard queue and a done-driven monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_adder;

   localparam int N = 8;

   logic clk;
   logic rst_n;
   int   cyc;

   int   n_checks;
   int   n_pass;
   int   done_pulses;

   logic [N:0] exp_q[$];   // {cout, sum}

   serial_adder_if #(.N(N)) bus ();

   serial_adder #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 'h%0h, required 'h%0h", nm, act, req);
   endtask

   // Monitor: every done pulse must match the oldest expected result.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            logic [N:0] e;
            done_pulses++;
            check("scoreboard non-empty at done", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("result {cout,sum}", 32'({bus.cout, bus.sum}), 32'(e));
            end
         end
      end
   end

   // One full operation with hand-supplied expected result. Operands and cin
   // are inverted right after acceptance; the result must not notice.
   task automatic do_op(input logic [N-1:0] xa, input logic [N-1:0] xb, input logic xc,
                        input logic [N-1:0] esum, input logic ecout, input string nm);
      int cycles;
      int busy_cyc;
      bit seen;
      bus.a     = xa;
      bus.b     = xb;
      bus.cin   = xc;
      bus.start = 1'b1;
      exp_q.push_back({ecout, esum});
      cycles   = 0;
      busy_cyc = 0;
      seen     = 0;
      while (!seen && cycles < N + 6) begin
         @(negedge clk);
         cycles++;
         if (cycles == 1) begin
            bus.start = 1'b0;
            bus.a     = ~xa;
            bus.b     = ~xb;
            bus.cin   = ~xc;
         end
         if (bus.busy === 1'b1) busy_cyc++;
         if (bus.done === 1'b1) seen = 1;
      end
      check({nm, " done latency"}, 32'(cycles), 32'(N + 1));
      check({nm, " busy cycles"}, 32'(busy_cyc), 32'(N));
      @(negedge clk);
      check({nm, " done one cycle"}, 32'(bus.done), 32'd0);
   endtask

   task automatic wait_done(input int bound, output bit seen);
      seen = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] ha [4];
      logic [N-1:0] hb [4];
      logic         hc [4];
      logic [N-1:0] hs [4];
      logic         hco[4];
      int  d0;
      int  prev;
      bit  seen;
      logic [N-1:0] ra, rb;
      logic rc;
      logic [N:0] t;

      cyc = 0; n_checks = 0; n_pass = 0; done_pulses = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

      // Reset state.
      @(negedge clk);
      check("reset sum", 32'(bus.sum), 32'd0);
      check("reset cout", 32'(bus.cout), 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed vectors.
      do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff+01");
      do_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "a5+5a+1");
      do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "00+00");
      do_op(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, "3c+0f");

      // start re-pulsed at cycle 3 of an operation is ignored.
      d0 = done_pulses;
      bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
      exp_q.push_back({1'b0, 8'h46});
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (N + 4) @(negedge clk);
      check("restart done pulses", 32'(done_pulses - d0), 32'd1);
      check("restart idle after", 32'(bus.busy), 32'd0);

      // Reset at cycle 4 of ADD aborts with no done.
      d0 = done_pulses;
      bus.a = 8'h55; bus.b = 8'h11; bus.cin = 1'b0; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid-add busy before reset", 32'(bus.busy), 32'd1);
      check("mid-add partial sum", 32'(bus.sum), 32'hC0);
      #2 rst_n = 1'b0;
      #1;
      check("async reset sum", 32'(bus.sum), 32'd0);
      check("async reset cout", 32'(bus.cout), 32'd0);
      check("async reset busy", 32'(bus.busy), 32'd0);
      check("async reset done", 32'(bus.done), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("no done across reset", 32'(done_pulses - d0), 32'd0);
      do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "7f+01 after reset");

      // start held high: back-to-back operations spaced N+2 cycles.
      ha = '{8'h01, 8'h80, 8'hF0, 8'h33};
      hb = '{8'h02, 8'h80, 8'h0F, 8'h44};
      hc = '{1'b0, 1'b0, 1'b1, 1'b1};
      hs = '{8'h03, 8'h00, 8'h00, 8'h78};
      hco = '{1'b0, 1'b1, 1'b1, 1'b0};
      bus.a = ha[0]; bus.b = hb[0]; bus.cin = hc[0]; bus.start = 1'b1;
      exp_q.push_back({hco[0], hs[0]});
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_done(2 * N + 6, seen);
         check("held start done seen", 32'(seen), 32'd1);
         if (i > 0) check("held start spacing", 32'(cyc - prev), 32'(N + 2));
         prev = cyc;
         if (i < 3) begin
            bus.a = ha[i+1]; bus.b = hb[i+1]; bus.cin = hc[i+1];
            exp_q.push_back({hco[i+1], hs[i+1]});
         end else begin
            bus.start = 1'b0;
         end
      end
      repeat (3) @(negedge clk);

      // Random operands against a+b+cin.
      for (int i = 0; i < 200; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         rc = 1'($urandom);
         t  = (N+1)'(ra) + (N+1)'(rb) + (N+1)'(rc);
         do_op(ra, rb, rc, t[N-1:0], t[N], "random");
      end

      repeat (4) @(negedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
